// File: rtl/majority_voter_seq.sv
// majority_voter_seq: registered N-way bitwise majority voter with per-channel error counters and sticky faults
module majority_voter_seq #(
  parameter int WIDTH  = 8,
  parameter int N      = 3,
  parameter int CNT_W  = 4,
  parameter int THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 unanimous,
  output logic [N-1:0]         mismatch,
  output logic [N*CNT_W-1:0]   err_cnt,
  output logic [N-1:0]         fault
);
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  if (N % 2 == 0 || N < 3 || N > 7) begin : g_bad_n
    $error("majority_voter_seq: N must be odd and in 3..7");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("majority_voter_seq: WIDTH must be at least 1");
  end
  if (THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_bad_thresh
    $error("majority_voter_seq: THRESH must be in 1..2^CNT_W-1");
  end
  logic [WIDTH-1:0] vote;
  logic [N-1:0]     mm;
  logic [CNT_W-1:0] nx [N];
  int               ones;
  // per-bit population count against the majority threshold
  always_comb begin
    vote = '0;
    ones = 0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) ones = ones + int'(in_data[i*WIDTH+b]);
      vote[b] = ones >= (N + 1) / 2;
    end
  end
  // channel disagreement and saturating next counter values
  always_comb begin
    mm = '0;
    for (int i = 0; i < N; i++) begin
      mm[i] = |(in_data[i*WIDTH +: WIDTH] ^ vote);
      nx[i] = (in_valid && mm[i] && !(&err_cnt[i*CNT_W +: CNT_W])) ? err_cnt[i*CNT_W +: CNT_W] + 1'b1 : err_cnt[i*CNT_W +: CNT_W];
    end
  end
  // vote registers, counters and sticky faults; clr_err beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      unanimous <= 1'b0;
      mismatch  <= '0;
      err_cnt   <= '0;
      fault     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= vote;
        mismatch  <= mm;
        unanimous <= ~|mm;
      end
      for (int i = 0; i < N; i++) begin
        err_cnt[i*CNT_W +: CNT_W] <= clr_err ? '0 : nx[i];
        fault[i] <= clr_err ? 1'b0 : (fault[i] | (nx[i] >= TH));
      end
    end
  end
endmodule

// File: tb/tb_majority_voter_seq.sv
// tb_majority_voter_seq: directed scoreboard bench for the 3-channel byte voter
module tb_majority_voter_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        unanimous;
  logic [2:0]  mismatch;
  logic [11:0] err_cnt;
  logic [2:0]  fault;

  majority_voter_seq #(.WIDTH(8), .N(3), .CNT_W(4), .THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .unanimous(unanimous), .mismatch(mismatch),
    .err_cnt(err_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic [2:0]  mm;
    logic        u;
    logic [11:0] cnt;
    logic [2:0]  f;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] md = '0;
  logic [2:0] mmm = '0;
  logic       mu = 1'b0;
  logic [3:0] mc [3] = '{4'd0, 4'd0, 4'd0};
  logic [2:0] mf = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md = '0; mmm = '0; mu = 1'b0; mf = '0;
    for (int i = 0; i < 3; i++) mc[i] = '0;
    q.delete();
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic v, input logic clr);
    logic [7:0] maj;
    logic [7:0] ch [3];
    exp_t e;
    exp_t r;
    in_data = {c, b, a};
    in_valid = v;
    clr_err = clr;
    maj = (a & b) | (a & c) | (b & c);
    ch[0] = a; ch[1] = b; ch[2] = c;
    if (v) begin
      md = maj;
      for (int i = 0; i < 3; i++) mmm[i] = ch[i] != maj;
      mu = mmm == 3'b000;
    end
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mc[i] = '0;
        mf[i] = 1'b0;
      end else if (v && ch[i] != maj) begin
        if (mc[i] != 4'hF) mc[i] = mc[i] + 4'd1;
        if (mc[i] >= 4'd4) mf[i] = 1'b1;
      end
    end
    e.d = md; e.v = v; e.mm = mmm; e.u = mu; e.cnt = {mc[2], mc[1], mc[0]}; e.f = mf;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err = 1'b0;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      r = q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(r.v));
      chk("out_data", 32'(out_data), 32'(r.d));
      chk("mismatch", 32'(mismatch), 32'(r.mm));
      chk("unanimous", 32'(unanimous), 32'(r.u));
      chk("err_cnt", 32'(err_cnt), 32'(r.cnt));
      chk("fault", 32'(fault), 32'(r.f));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(out_data), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_unan"}, 32'(unanimous), 32'h0);
    chk({tag, "_mm"}, 32'(mismatch), 32'h0);
    chk({tag, "_cnt"}, 32'(err_cnt), 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
    step(8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b0);
    step(8'h01, 8'h02, 8'h03, 1'b1, 1'b1);
    repeat (20) step(8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0);
    step(8'h3C, 8'h3C, 8'h00, 1'b1, 1'b1);
    step(8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    step(8'h80, 8'h7F, 8'h7F, 1'b1, 1'b0);
    step(8'hAA, 8'h55, 8'h00, 1'b0, 1'b0);
    step(8'hC3, 8'h81, 8'h42, 1'b1, 1'b0);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++)
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    repeat (3) step(8'h10, 8'h20, 8'h30, 1'b1, 1'b0);
    in_data = {8'h0F, 8'h0F, 8'hF0};
    in_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_valid", 32'(out_valid), 32'h0);
    step(8'h5A, 8'h5A, 8'hA5, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/majority_voter_seq.md
# majority_voter_seq

Registered, parametrised N-way bitwise majority voter with per-channel disagreement tracking. Each valid cycle it takes N redundant WIDTH-bit words, outputs their bitwise majority one clock later, and flags channels that disagree with the vote. Per-channel saturating error counters raise a sticky fault flag once a threshold is reached. The block sits behind replicated (TMR/NMR) datapaths and replaces the single-bit combinational 3-input majority gate.

## Interface
- WIDTH, 8: data width per channel, ≥1
- N, 3: channel count; odd, 3..7
- CNT_W, 4: width of each error counter
- THRESH, 4: error count at which a channel's fault flag sets; 1..2^CNT_W-1

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  1  in_data is valid this cycle
- clr_err  in  1  synchronous clear of all counters and fault flags
- out_data  out  WIDTH  registered bitwise majority
- out_valid  out  1  out_data, mismatch and unanimous are valid
- unanimous  out  1  all N channels were identical in the voted sample
- mismatch  out  N  bit i = channel i differed from vote in ≥1 bit
- err_cnt  out  N*CNT_W  channel i counter in bits [i*CNT_W +: CNT_W]
- fault  out  N  sticky per-channel fault flag

## Operation
- Vote: for each bit b, count channels with bit b = 1. out bit b = 1 iff count ≥ (N+1)/2. N is odd, so ties cannot occur.
- Channel i mismatches when (in_data channel i XOR vote) is nonzero. unanimous = no channel mismatches.
- Cycle with in_valid=1:
  - register vote into out_data, mismatch, unanimous
  - out_valid ← 1
  - for each mismatching channel, err_cnt[i] ← err_cnt[i]+1, saturating at 2^CNT_W-1 (no wrap)
- Cycle with in_valid=0:
  - out_valid ← 0
  - out_data, mismatch, unanimous hold their previous values
  - counters unchanged
- fault[i] ← 1 on the edge where the updated err_cnt[i] ≥ THRESH. It stays 1 until clr_err or reset, even if counting stops.
- clr_err=1: all err_cnt ← 0 and all fault ← 0 on that edge. clr_err has priority over a same-cycle increment; that cycle's mismatches are not counted. The vote registers still update normally.
- Multiple channels may mismatch in one cycle, each on different bits. Each of them increments.
- Parameter checks: an elaboration-time error is required if N is even, N<3, N>7, or THRESH is out of range.

## Timing
- Latency: 1 cycle from in_valid/in_data sampled to out_valid/out_data/mismatch/unanimous.
- Back-to-back: throughput is one vote per cycle. There is no backpressure.
- Fault timing: the fault flag asserts on the same edge that err_cnt reaches THRESH, so both are visible together one cycle after the offending input.
- Reset values (async on rst_n low, asynchronous to clk):
  - out_data = 0
  - out_valid = 0
  - unanimous = 0
  - mismatch = 0
  - err_cnt = 0
  - fault = 0
- Reset mid-stream: the in-flight vote is discarded. The first valid sample after rst_n rises produces out_valid one cycle later.
- Outputs are pure register outputs. There is no combinational path from inputs to outputs.

## Test plan
(N=3, WIDTH=8, CNT_W=4, THRESH=4)
- Reset, then all channels 8'hA5 with in_valid=1 → next cycle out_data=8'hA5, out_valid=1, unanimous=1, mismatch=3'b000, err_cnt all 0.
- ch0=8'hFF, ch1=8'h0F, ch2=8'hF0 → out_data=8'hFF, mismatch=3'b110, unanimous=0, err_cnt[1]=err_cnt[2]=1.
- ch2=8'h00 while ch0=ch1=8'h3C for 4 consecutive valid cycles → err_cnt[2] reads 1,2,3,4 and fault=3'b100 on the 4th output cycle. Then 16 more cycles → err_cnt[2] saturates at 15 and fault stays set.
- With err_cnt[2]=15, assert clr_err in the same cycle as a ch2 mismatch → err_cnt all 0, fault=0. out_data still reflects that cycle's vote.
- Interleave in_valid=0 cycles → out_valid drops, out_data holds, counters unchanged. Then pull rst_n low mid-stream off a clock edge → all outputs 0 immediately.
- N=5 build: channels 1,1,1,0,0 on bit 0 → bit 0 = 1. Channels 1,1,0,0,0 → bit 0 = 0, mismatch flags only the two minority channels in each case.
